i2s_capture_multi: RTL and testbench

Parametrised I2S microphone front end: generates BCLK/LRCLK for an I2S MEMS microphone, deserialises both left and right slots, and combines them per frame according to a runtime mode. It then writes one sample per (decimated) frame into the FFT sample buffer. It sits between the microphone pins and `FFT_processor`, replacing `mic_translator` with stereo capture, channel mixing, decimation and a hold control. It pulses `start` each time the buffer has been filled.

---
 rtl/i2s_capture_multi.sv | 127 ++++++++++++
 tb/tb_i2s_capture_multi.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_capture_multi.sv
// i2s_capture_multi
// I2S MEMS microphone front end. Generates BCLK/LRCLK from a free-running
// 7-bit frame counter and captures both slots. Each frame it combines left
// and right according to mode, then writes the decimated result into the
// sample buffer. start pulses after the write to the last buffer address.
module i2s_capture_multi #(
    parameter int ADDR_WIDTH = 9,
    parameter int MIC_BITS   = 18,
    parameter int DECIM      = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       DOUT,
    input  logic [1:0]                 mode,
    input  logic                       hold,
    output logic                       BCLK,
    output logic                       LRCLK,
    output logic                       mic_we,
    output logic [ADDR_WIDTH-1:0]      mic_addr,
    output logic signed [MIC_BITS-1:0] mic_data,
    output logic                       start
);
    localparam int              DCW      = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCW-1:0]  DLAST    = DCW'(DECIM - 1);
    localparam logic [4:0]      LAST_BIT = 5'(MIC_BITS);

    logic [6:0]                 r_cnt;
    logic [MIC_BITS-1:0]        r_sh;
    logic signed [MIC_BITS-1:0] r_left;
    logic signed [MIC_BITS-1:0] r_right;
    logic [ADDR_WIDTH-1:0]      r_wptr;
    logic [DCW-1:0]             r_dcnt;

    logic [4:0]                 w_bit_idx;
    logic                       w_bit_take;
    logic [MIC_BITS-1:0]        w_sh_next;
    logic                       w_mid_edge;
    logic                       w_wrap_edge;
    logic                       w_write;
    logic signed [MIC_BITS-1:0] w_mix;

    // Channel combiner: sum/difference carried one bit wider, then halved
    // with an arithmetic shift, so the result always fits MIC_BITS.
    function automatic logic signed [MIC_BITS-1:0] mix_sample(
        input logic [1:0]                 m,
        input logic signed [MIC_BITS-1:0] l,
        input logic signed [MIC_BITS-1:0] r
    );
        logic signed [MIC_BITS:0]   l_ext;
        logic signed [MIC_BITS:0]   r_ext;
        logic signed [MIC_BITS:0]   acc;
        logic signed [MIC_BITS-1:0] res;
        l_ext = {l[MIC_BITS-1], l};
        r_ext = {r[MIC_BITS-1], r};
        acc   = '0;
        res   = l;
        case (m)
            2'd0: res = l;
            2'd1: res = r;
            2'd2: begin
                acc = l_ext + r_ext;
                res = acc[MIC_BITS:1];
            end
            default: begin
                acc = l_ext - r_ext;
                res = acc[MIC_BITS:1];
            end
        endcase
        return res;
    endfunction

    // Slot bit decode: bit 0 is the I2S delay slot, bits past MIC_BITS are padding.
    assign w_bit_idx   = r_cnt[5:1];
    assign w_bit_take  = r_cnt[0] && (w_bit_idx != 5'd0) && (w_bit_idx <= LAST_BIT);
    assign w_sh_next   = w_bit_take ? {r_sh[MIC_BITS-2:0], DOUT} : r_sh;
    assign w_mid_edge  = (r_cnt == 7'd63);
    assign w_wrap_edge = (r_cnt == 7'd127);
    assign w_mix       = mix_sample(mode, r_left, w_sh_next);
    assign w_write     = w_wrap_edge && !hold && (r_dcnt == DLAST);

    assign BCLK  = r_cnt[0];
    assign LRCLK = r_cnt[6];

    // Frame counter and serial capture; the last data bit of a slot may land
    // on the latch edge, so L/R take the shift register's next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sh    <= '0;
            r_left  <= '0;
            r_right <= '0;
        end else begin
            r_cnt <= r_cnt + 7'd1;
            r_sh  <= w_sh_next;
            if (w_mid_edge) begin
                r_left <= w_sh_next;
            end
            if (w_wrap_edge) begin
                r_right <= w_sh_next;
            end
        end
    end

    // Buffer write path: decimation, hold freeze, pointer wrap and full pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr   <= '0;
            r_dcnt   <= '0;
            mic_we   <= 1'b0;
            mic_addr <= '0;
            mic_data <= '0;
            start    <= 1'b0;
        end else begin
            mic_we <= 1'b0;
            start  <= mic_we && (&mic_addr);
            if (w_wrap_edge && !hold) begin
                r_dcnt <= (r_dcnt == DLAST) ? '0 : r_dcnt + DCW'(1);
            end
            if (w_write) begin
                mic_we   <= 1'b1;
                mic_addr <= r_wptr;
                mic_data <= w_mix;
                r_wptr   <= r_wptr + ADDR_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_i2s_capture_multi.sv
// Bench for i2s_capture_multi: two instances (DECIM=1 and DECIM=4, 8-entry
// buffer) share the serial input. Frames are described as L/R/mode/hold
// values; expected writes are derived from those with plain arithmetic.
module tb_i2s_capture_multi;
    localparam int AW = 3;
    localparam int MB = 18;
    localparam int DB = 4;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          dout = 1'b0;
    logic          hold = 1'b0;
    logic [1:0]    mode = 2'd0;

    logic          a_bclk, a_lr, a_we, a_start;
    logic [AW-1:0] a_addr;
    logic [MB-1:0] a_data;
    logic          b_bclk, b_lr, b_we, b_start;
    logic [AW-1:0] b_addr;
    logic [MB-1:0] b_data;

    always #5 clk = ~clk;

    i2s_capture_multi #(.ADDR_WIDTH(AW), .MIC_BITS(MB), .DECIM(1)) dut_a (
        .clk(clk), .rst(rst), .DOUT(dout), .mode(mode), .hold(hold),
        .BCLK(a_bclk), .LRCLK(a_lr), .mic_we(a_we), .mic_addr(a_addr),
        .mic_data(a_data), .start(a_start)
    );

    i2s_capture_multi #(.ADDR_WIDTH(AW), .MIC_BITS(MB), .DECIM(DB)) dut_b (
        .clk(clk), .rst(rst), .DOUT(dout), .mode(mode), .hold(hold),
        .BCLK(b_bclk), .LRCLK(b_lr), .mic_we(b_we), .mic_addr(b_addr),
        .mic_data(b_data), .start(b_start)
    );

    int checks = 0;
    int errors = 0;

    logic [MB-1:0] fL[16];
    logic [MB-1:0] fR[16];
    logic [1:0]    fmode[16];
    logic          fhold[16];

    int oa_wc[$], oa_wa[$], oa_wd[$], oa_sc[$];
    int ob_wc[$], ob_wa[$], ob_wd[$], ob_sc[$];
    int ea_wc[$], ea_wa[$], ea_wd[$], ea_sc[$];
    int eb_wc[$], eb_wa[$], eb_wd[$], eb_sc[$];
    logic obs_b[$];
    logic obs_lr[$];
    int hold_viol;

    // Reference combiner using 32-bit integer arithmetic.
    function automatic int mixref(input logic [1:0] m, input logic [MB-1:0] l, input logic [MB-1:0] r);
        int li, ri, res;
        li = l[MB-1] ? int'(l) - (1 << MB) : int'(l);
        ri = r[MB-1] ? int'(r) - (1 << MB) : int'(r);
        case (m)
            2'd0: res = li;
            2'd1: res = ri;
            2'd2: res = (li + ri) >>> 1;
            default: res = (li - ri) >>> 1;
        endcase
        return res & ((1 << MB) - 1);
    endfunction

    task automatic rand_frames();
        for (int k = 0; k < 16; k++) begin
            fL[k]    = MB'($urandom);
            fR[k]    = MB'($urandom);
            fmode[k] = 2'($urandom_range(0, 3));
            fhold[k] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected writes: a frame counts unless held; every DECIM-th counted
    // frame is written one cycle after its wrap, to the next buffer slot.
    task automatic build_expected(input int ncyc);
        ea_wc.delete(); ea_wa.delete(); ea_wd.delete(); ea_sc.delete();
        eb_wc.delete(); eb_wa.delete(); eb_wd.delete(); eb_sc.delete();
        for (int s = 0; s < 2; s++) begin
            int d, nh, wc, ad, dv;
            d  = (s == 0) ? 1 : DB;
            nh = 0;
            for (int k = 0; k < 16 && 128 * (k + 1) < ncyc; k++) begin
                wc = 128 * (k + 1);
                if (!fhold[k]) begin
                    nh++;
                    if (nh % d == 0) begin
                        ad = (nh / d - 1) % (1 << AW);
                        dv = mixref(fmode[k], fL[k], fR[k]);
                        if (s == 0) begin
                            ea_wc.push_back(wc); ea_wa.push_back(ad); ea_wd.push_back(dv);
                            if (ad == (1 << AW) - 1 && wc + 1 < ncyc) ea_sc.push_back(wc + 1);
                        end else begin
                            eb_wc.push_back(wc); eb_wa.push_back(ad); eb_wd.push_back(dv);
                            if (ad == (1 << AW) - 1 && wc + 1 < ncyc) eb_sc.push_back(wc + 1);
                        end
                    end
                end
            end
        end
    endtask

    // Drives ncyc cycles starting at cycle 0 (called right after reset
    // release) and records what both instances do. mode/hold are random
    // except in the last cycle of each frame, where the frame's values apply.
    task automatic run_cycles(input int ncyc);
        int pa, pd;
        oa_wc.delete(); oa_wa.delete(); oa_wd.delete(); oa_sc.delete();
        ob_wc.delete(); ob_wa.delete(); ob_wd.delete(); ob_sc.delete();
        obs_b.delete(); obs_lr.delete();
        hold_viol = 0;
        pa = int'(a_addr);
        pd = int'(a_data);
        for (int n = 0; n < ncyc; n++) begin
            int c, k, b;
            c = n % 128;
            k = n / 128;
            obs_b.push_back(a_bclk);
            obs_lr.push_back(a_lr);
            if (a_we) begin
                oa_wc.push_back(n); oa_wa.push_back(int'(a_addr)); oa_wd.push_back(int'(a_data));
            end else if (int'(a_addr) != pa || int'(a_data) != pd) begin
                hold_viol++;
            end
            pa = int'(a_addr);
            pd = int'(a_data);
            if (a_start) oa_sc.push_back(n);
            if (b_we) begin
                ob_wc.push_back(n); ob_wa.push_back(int'(b_addr)); ob_wd.push_back(int'(b_data));
            end
            if (b_start) ob_sc.push_back(n);
            b = (c % 64) / 2;
            if (c % 2 == 1 && b >= 1 && b <= MB)
                dout = (c < 64) ? fL[k][MB - b] : fR[k][MB - b];
            else
                dout = 1'($urandom_range(0, 1));
            if (c == 127) begin
                mode = fmode[k];
                hold = fhold[k];
            end else begin
                mode = 2'($urandom_range(0, 3));
                hold = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 8;
        if (a_bclk !== 1'b0)  begin errors++; $display("FAIL reset_bclk got %b want 0", a_bclk); end
        if (a_lr !== 1'b0)    begin errors++; $display("FAIL reset_lrclk got %b want 0", a_lr); end
        if (a_we !== 1'b0)    begin errors++; $display("FAIL reset_we got %b want 0", a_we); end
        if (a_addr !== '0)    begin errors++; $display("FAIL reset_addr got %0d want 0", a_addr); end
        if (a_data !== '0)    begin errors++; $display("FAIL reset_data got %h want 0", a_data); end
        if (a_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", a_start); end
        if (b_we !== 1'b0)    begin errors++; $display("FAIL reset_we_d4 got %b want 0", b_we); end
        if (b_addr !== '0)    begin errors++; $display("FAIL reset_addr_d4 got %0d want 0", b_addr); end
        rand_frames();
        run_cycles(260);
        for (int n = 0; n < 260; n++) begin
            checks += 2;
            if (obs_b[n] !== 1'(n % 2)) begin
                errors++; $display("FAIL bclk cycle %0d got %b want %0d", n, obs_b[n], n % 2);
            end
            if (obs_lr[n] !== 1'((n / 64) % 2)) begin
                errors++; $display("FAIL lrclk cycle %0d got %b want %0d", n, obs_lr[n], (n / 64) % 2);
            end
        end
    endtask

    task automatic test_modes();
        int exp_d[4];
        exp_d = '{32'h20001, 32'h00003, 32'h30002, 32'h2FFFF};
        do_reset();
        rand_frames();
        for (int k = 0; k < 4; k++) begin
            fL[k] = 18'h20001; fR[k] = 18'h00003; fmode[k] = 2'(k);
        end
        run_cycles(4 * 128 + 2);
        checks++;
        if (oa_wc.size() != 4) begin
            errors++; $display("FAIL modes_count got %0d want 4", oa_wc.size());
        end
        for (int i = 0; i < 4 && i < oa_wc.size(); i++) begin
            checks += 2;
            if (oa_wc[i] != 128 * (i + 1)) begin
                errors++; $display("FAIL modes_cycle mode %0d got %0d want %0d", i, oa_wc[i], 128 * (i + 1));
            end
            if (oa_wd[i] != exp_d[i]) begin
                errors++; $display("FAIL modes_data mode %0d got %h want %h", i, oa_wd[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_random_wrap();
        do_reset();
        rand_frames();
        run_cycles(12 * 128 + 2);
        build_expected(12 * 128 + 2);
        checks += 4;
        if (oa_wc.size() != ea_wc.size()) begin errors++; $display("FAIL wrap_count got %0d want %0d", oa_wc.size(), ea_wc.size()); end
        if (ob_wc.size() != eb_wc.size()) begin errors++; $display("FAIL decim_count got %0d want %0d", ob_wc.size(), eb_wc.size()); end
        if (oa_sc.size() != 1 || oa_sc[0] != 1025) begin errors++; $display("FAIL wrap_start got %0d pulses first %0d want one at 1025", oa_sc.size(), (oa_sc.size() > 0) ? oa_sc[0] : -1); end
        if (hold_viol != 0) begin errors++; $display("FAIL data_hold got %0d changes want 0", hold_viol); end
        for (int i = 0; i < ea_wc.size() && i < oa_wc.size(); i++) begin
            checks++;
            if (oa_wc[i] != ea_wc[i] || oa_wa[i] != ea_wa[i] || oa_wd[i] != ea_wd[i]) begin
                errors++; $display("FAIL wrap_write %0d got c%0d a%0d d%h want c%0d a%0d d%h", i, oa_wc[i], oa_wa[i], oa_wd[i], ea_wc[i], ea_wa[i], ea_wd[i]);
            end
        end
        checks++;
        if (oa_wa.size() > 8 && oa_wa[8] != 0) begin errors++; $display("FAIL wrap_ninth_addr got %0d want 0", oa_wa[8]); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= ob_wc.size() || ob_wc[i] != 512 * (i + 1) || ob_wa[i] != i || ob_wd[i] != eb_wd[i]) begin
                errors++; $display("FAIL decim_write %0d got c%0d a%0d want c%0d a%0d", i,
                                   (i < ob_wc.size()) ? ob_wc[i] : -1, (i < ob_wa.size()) ? ob_wa[i] : -1, 512 * (i + 1), i);
            end
        end
        checks++;
        if (ob_sc.size() != eb_sc.size()) begin errors++; $display("FAIL decim_start got %0d pulses want %0d", ob_sc.size(), eb_sc.size()); end
    endtask

    task automatic test_hold();
        do_reset();
        rand_frames();
        fhold[2] = 1'b1;
        run_cycles(6 * 128 + 2);
        build_expected(6 * 128 + 2);
        checks += 3;
        if (oa_wc.size() != ea_wc.size()) begin errors++; $display("FAIL hold_count got %0d want %0d", oa_wc.size(), ea_wc.size()); end
        if (ob_wc.size() != eb_wc.size()) begin errors++; $display("FAIL hold_count_d4 got %0d want %0d", ob_wc.size(), eb_wc.size()); end
        if (oa_wc.size() > 2 && (oa_wc[2] != 512 || oa_wa[2] != 2)) begin
            errors++; $display("FAIL hold_resume got c%0d a%0d want c512 a2", oa_wc[2], oa_wa[2]);
        end
        for (int i = 0; i < ea_wc.size() && i < oa_wc.size(); i++) begin
            checks++;
            if (oa_wc[i] != ea_wc[i] || oa_wa[i] != ea_wa[i] || oa_wd[i] != ea_wd[i]) begin
                errors++; $display("FAIL hold_write %0d got c%0d a%0d d%h want c%0d a%0d d%h", i, oa_wc[i], oa_wa[i], oa_wd[i], ea_wc[i], ea_wa[i], ea_wd[i]);
            end
        end
        for (int i = 0; i < eb_wc.size() && i < ob_wc.size(); i++) begin
            checks++;
            if (ob_wc[i] != eb_wc[i] || ob_wa[i] != eb_wa[i] || ob_wd[i] != eb_wd[i]) begin
                errors++; $display("FAIL hold_write_d4 %0d got c%0d a%0d d%h want c%0d a%0d d%h", i, ob_wc[i], ob_wa[i], ob_wd[i], eb_wc[i], eb_wa[i], eb_wd[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_frames();
        run_cycles(200);
        checks++;
        if (oa_wc.size() != 1) begin errors++; $display("FAIL pre_reset_writes got %0d want 1", oa_wc.size()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks += 4;
        if (a_addr !== '0)             begin errors++; $display("FAIL midrst_addr got %0d want 0", a_addr); end
        if (a_data !== '0)             begin errors++; $display("FAIL midrst_data got %h want 0", a_data); end
        if ({a_lr, a_bclk} !== 2'b00)  begin errors++; $display("FAIL midrst_cnt got lr%b bclk%b want 00", a_lr, a_bclk); end
        if (a_we !== 1'b0)             begin errors++; $display("FAIL midrst_we got %b want 0", a_we); end
        rand_frames();
        run_cycles(3 * 128 + 2);
        build_expected(3 * 128 + 2);
        checks += 3;
        if (oa_wc.size() != ea_wc.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", oa_wc.size(), ea_wc.size()); end
        if (oa_wc.size() == 0 || oa_wc[0] != 128 || oa_wa[0] != 0) begin
            errors++; $display("FAIL midrst_first got c%0d a%0d want c128 a0",
                               (oa_wc.size() > 0) ? oa_wc[0] : -1, (oa_wa.size() > 0) ? oa_wa[0] : -1);
        end
        if (oa_sc.size() != 0 || ob_sc.size() != 0) begin errors++; $display("FAIL midrst_start got %0d pulses want 0", oa_sc.size() + ob_sc.size()); end
        for (int i = 0; i < ea_wc.size() && i < oa_wc.size(); i++) begin
            checks++;
            if (oa_wc[i] != ea_wc[i] || oa_wa[i] != ea_wa[i] || oa_wd[i] != ea_wd[i]) begin
                errors++; $display("FAIL midrst_write %0d got c%0d a%0d d%h want c%0d a%0d d%h", i, oa_wc[i], oa_wa[i], oa_wd[i], ea_wc[i], ea_wa[i], ea_wd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_random_wrap();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
